// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divide unit.
interface div_unit_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, op, a, b, flush, input busy, done, result);
   modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider, one quotient bit per cycle,
// with a one-cycle operand-prep step and a fast path for divide-by-zero and signed overflow.
module div_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic       clk,
   input logic       rst_n,
   div_unit_if.slave div_io
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = XLEN'(1) << (XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_DONE
   } state_e;

   state_e          state_q;
   logic [1:0]      op_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN:0]   rem_q;
   logic [XLEN-1:0] quo_q;
   logic [CNT_W-1:0] cnt_q;
   logic            neg_quo_q;
   logic            neg_rem_q;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] result_q;

   logic            is_signed;
   logic            is_rem;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic            div_by_zero;
   logic            sgn_ovf;
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] trial;
   logic            q_bit;
   logic [XLEN:0]   rem_nx;
   logic [XLEN-1:0] quo_nx;
   logic [XLEN-1:0] quo_fin;
   logic [XLEN-1:0] rem_fin;

   assign is_signed   = ~op_q[0];
   assign is_rem      = op_q[1];
   assign a_abs       = (is_signed && a_q[XLEN-1]) ? (~a_q + XLEN'(1)) : a_q;
   assign b_abs       = (is_signed && b_q[XLEN-1]) ? (~b_q + XLEN'(1)) : b_q;
   assign div_by_zero = (b_q == '0);
   assign sgn_ovf     = is_signed && (a_q == INT_MIN) && (b_q == '1);

   // One restoring step: shift in the next dividend bit, keep the subtraction if no borrow.
   assign rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
   assign trial   = {1'b0, rem_sh} - {2'b00, b_q};
   assign q_bit   = ~trial[XLEN+1];
   assign rem_nx  = q_bit ? trial[XLEN:0] : rem_sh;
   assign quo_nx  = {quo_q[XLEN-2:0], q_bit};
   assign quo_fin = neg_quo_q ? (~quo_nx + XLEN'(1)) : quo_nx;
   assign rem_fin = neg_rem_q ? (~rem_nx[XLEN-1:0] + XLEN'(1)) : rem_nx[XLEN-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (div_io.start && !div_io.flush) begin
                  op_q    <= div_io.op;
                  a_q     <= div_io.a;
                  b_q     <= div_io.b;
                  busy_q  <= 1'b1;
                  state_q <= S_PREP;
               end
            end
            // Resolve special cases, otherwise load operand magnitudes for iteration.
            S_PREP: begin
               if (div_io.flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (div_by_zero) begin
                  result_q <= is_rem ? a_q : '1;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else if (sgn_ovf) begin
                  result_q <= is_rem ? '0 : INT_MIN;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  neg_quo_q <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                  neg_rem_q <= is_signed && a_q[XLEN-1];
                  quo_q     <= a_abs;
                  b_q       <= b_abs;
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               if (div_io.flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(XLEN - 1)) begin
                     result_q <= is_rem ? rem_fin : quo_fin;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign div_io.busy   = busy_q;
   assign div_io.done   = done_q;
   assign div_io.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

   localparam int unsigned XLEN     = 32;
   localparam int          LAT_NORM = 33;
   localparam int          LAT_FAST = 1;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   div_unit_if #(.XLEN(XLEN)) dif ();

   div_unit #(.XLEN(XLEN)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .div_io (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V M semantics written directly with language division.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic is_rem;
      logic sgn;
      is_rem = op[1];
      sgn    = ~op[0];
      if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
         return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      end
      return is_rem ? (a % b) : (a / b);
   endfunction

   function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      if (b == 32'd0) return LAT_FAST;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_FAST;
      return LAT_NORM;
   endfunction

   // Issue one request, wait (bounded) for done, check latency, busy, result and return to idle.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
      int   lat;
      logic busy_ok;
      @(negedge clk);
      dif.start = 1'b1;
      dif.op    = op;
      dif.a     = a;
      dif.b     = b;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      dif.a     = ~a;
      dif.b     = ~b;
      lat     = 0;
      busy_ok = dif.busy;
      while (!dif.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         busy_ok = busy_ok & dif.busy;
      end
      chk(32'(lat), 32'(model_lat(op, a, b)), {tag, "_lat"});
      chk({31'd0, busy_ok}, 32'd1, {tag, "_busy"});
      chk(dif.result, model(op, a, b), {tag, "_res"});
      @(posedge clk);
      #1;
      chk({30'd0, dif.busy, dif.done}, 32'd0, {tag, "_idle"});
   endtask

   initial begin
      logic [31:0] prior;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          lat;
      int          done_cnt;

      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      dif.start = 1'b0;
      dif.op    = 2'b00;
      dif.a     = '0;
      dif.b     = '0;
      dif.flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({30'd0, dif.busy, dif.done}, 32'd0, "reset_busy_done");
      chk(dif.result, 32'd0, "reset_result");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      do_op(2'b01, 32'd100, 32'd7, "divu_100_7");
      do_op(2'b11, 32'd100, 32'd7, "remu_100_7");
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      do_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
      do_op(2'b01, 32'd5, 32'd0, "divu_by0");
      do_op(2'b11, 32'd5, 32'd0, "remu_by0");
      do_op(2'b00, 32'hFFFF_FFFB, 32'd0, "div_m5_by0");
      do_op(2'b10, 32'hFFFF_FFFB, 32'd0, "rem_m5_by0");
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
      do_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1");

      // Flush mid-run: no done, busy drops, result keeps its prior value.
      prior = dif.result;
      @(negedge clk);
      dif.start = 1'b1;
      dif.op    = 2'b01;
      dif.a     = 32'd100;
      dif.b     = 32'd7;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      done_cnt  = 0;
      repeat (9) begin
         @(posedge clk);
         #1;
         if (dif.done) done_cnt++;
      end
      @(negedge clk);
      dif.flush = 1'b1;
      @(posedge clk);
      #1;
      dif.flush = 1'b0;
      chk({31'd0, dif.busy}, 32'd0, "flush_busy");
      chk({31'd0, dif.done}, 32'd0, "flush_done");
      chk(dif.result, prior, "flush_result");
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dif.done) done_cnt++;
      end
      chk(32'(done_cnt), 32'd0, "flush_no_done");

      // Flush together with start in IDLE: request dropped.
      @(negedge clk);
      dif.start = 1'b1;
      dif.flush = 1'b1;
      dif.op    = 2'b01;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      dif.flush = 1'b0;
      chk({31'd0, dif.busy}, 32'd0, "flush_start_drop");

      // Start held high throughout busy: exactly one done, operands sampled only at accept.
      @(negedge clk);
      dif.start = 1'b1;
      dif.op    = 2'b01;
      dif.a     = 32'd1000;
      dif.b     = 32'd3;
      @(posedge clk);
      #1;
      dif.a    = 32'd55;
      dif.b    = 32'd11;
      lat      = 0;
      done_cnt = 0;
      while (!dif.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk(32'(lat), 32'(LAT_NORM), "held_start_lat");
      chk(dif.result, 32'd333, "held_start_res");
      @(negedge clk);
      dif.start = 1'b0;
      @(posedge clk);
      #1;
      chk({30'd0, dif.busy, dif.done}, 32'd0, "held_start_idle");
      do_op(2'b11, 32'd1000, 32'd3, "after_held");

      // Asynchronous reset mid-run clears outputs immediately.
      @(negedge clk);
      dif.start = 1'b1;
      dif.op    = 2'b00;
      dif.a     = 32'd12345;
      dif.b     = 32'd67;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk({30'd0, dif.busy, dif.done}, 32'd0, "rst_mid_busy_done");
      chk(dif.result, 32'd0, "rst_mid_result");
      @(negedge clk);
      rst_n = 1'b1;
      do_op(2'b00, 32'd12345, 32'd67, "after_rst");

      // Random regression with some biased corner operands.
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: ;
         endcase
         do_op(rop, ra, rb, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
